// File: rtl/sramlike_axi_bridge_if.sv
// AXI3 master-side bus bundle used by the SRAM-like bridge.
// Master drives requests/write data, slave drives responses.
interface sramlike_axi_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// SRAM-like to AXI3 master bridge: one registered burst at a time,
// internal beat counter drives wlast and validates rlast.
module sramlike_axi_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int RD_ID  = 0,
  parameter int WR_ID  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              addr_ok,
  output logic              data_ok,
  output logic              last_ok,
  output logic              wb_ok,
  output logic              resp_err,
  output logic              busy,
  sramlike_axi_bridge_if.master axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA,
    WR_ADDR, WR_DATA, WR_RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_len;
  logic [2:0]        a_size;
  logic [1:0]        a_burst;
  logic [7:0]        cnt;
  logic              err;

  logic is_last, take, r_hs, w_hs, b_hs;
  logic arvalid_c, awvalid_c, rready_c;
  logic wvalid_c, bready_c;
  logic addr_ok_c, data_ok_c, last_ok_c, wb_ok_c;
  logic [STRB_W-1:0] strb;

  assign is_last = (cnt == a_len);
  assign take    = (state == IDLE) && req;
  assign r_hs    = (state == RD_DATA) && axi.rvalid;
  assign w_hs    = (state == WR_DATA) && req && axi.wready;
  assign b_hs    = (state == WR_RESP) && axi.bvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = wr ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (axi.arready) state_nx = RD_DATA;
      RD_DATA: if (axi.rvalid && is_last) state_nx = IDLE;
      WR_ADDR: if (axi.awready) state_nx = WR_DATA;
      WR_DATA: if (w_hs && is_last) state_nx = WR_RESP;
      WR_RESP: if (axi.bvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    arvalid_c = 1'b0;
    awvalid_c = 1'b0;
    rready_c  = 1'b0;
    wvalid_c  = 1'b0;
    bready_c  = 1'b0;
    addr_ok_c = 1'b0;
    data_ok_c = 1'b0;
    last_ok_c = 1'b0;
    wb_ok_c   = 1'b0;
    unique case (state)
      RD_ADDR: begin
        arvalid_c = 1'b1;
        addr_ok_c = axi.arready;
      end
      RD_DATA: begin
        rready_c  = 1'b1;
        data_ok_c = axi.rvalid;
        last_ok_c = axi.rvalid && is_last;
        wb_ok_c   = axi.rvalid && is_last;
      end
      WR_ADDR: begin
        awvalid_c = 1'b1;
        addr_ok_c = axi.awready;
      end
      WR_DATA: begin
        wvalid_c  = req;
        data_ok_c = w_hs;
        last_ok_c = w_hs && is_last;
      end
      WR_RESP: begin
        bready_c = 1'b1;
        wb_ok_c  = axi.bvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_addr  <= '0;
      a_len   <= '0;
      a_size  <= '0;
      a_burst <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (take) begin
        a_addr  <= addr;
        a_len   <= len;
        a_size  <= size;
        a_burst <= burst;
        cnt     <= '0;
        err     <= 1'b0;
      end
      if (r_hs) begin
        cnt <= cnt + 8'd1;
        // rlast must coincide exactly with our own final-beat count
        if ((|axi.rresp) || (axi.rlast != is_last))
          err <= 1'b1;
      end
      if (w_hs) cnt <= cnt + 8'd1;
      if (b_hs && (|axi.bresp)) err <= 1'b1;
    end
  end

  // Single-beat writes carry a narrow lane mask; bursts use full lanes.
  always_comb begin
    strb = '1;
    if (a_len == 8'd0) begin
      for (int i = 0; i < STRB_W; i++) begin
        strb[i] = (i >= int'(a_addr[OFF_W-1:0])) &&
                  (i < int'(a_addr[OFF_W-1:0]) +
                       int'(32'd1 << a_size));
      end
    end
  end

  assign axi.arid    = ID_W'(RD_ID);
  assign axi.araddr  = a_addr;
  assign axi.arlen   = a_len;
  assign axi.arsize  = a_size;
  assign axi.arburst = a_burst;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;

  assign axi.awid    = ID_W'(WR_ID);
  assign axi.awaddr  = a_addr;
  assign axi.awlen   = a_len;
  assign axi.awsize  = a_size;
  assign axi.awburst = a_burst;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_c;

  assign axi.wid     = ID_W'(WR_ID);
  assign axi.wdata   = wdata_i;
  assign axi.wstrb   = strb;
  assign axi.wlast   = is_last;
  assign axi.wvalid  = wvalid_c;
  assign axi.bready  = bready_c;

  assign rdata_o  = axi.rdata;
  assign addr_ok  = addr_ok_c;
  assign data_ok  = data_ok_c;
  assign last_ok  = last_ok_c;
  assign wb_ok    = wb_ok_c;
  assign resp_err = err;
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Randomised bench for sramlike_axi_bridge against a
// transaction-level model, plus a 64-bit lane-mask probe.
module tb_sramlike_axi_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int P_IDLE = 0;
  localparam int P_ADDR = 1;
  localparam int P_DATA = 2;
  localparam int P_RESP = 3;
  localparam int LIMIT  = 5000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          req, wr;
  logic [2:0]    size;
  logic [AW-1:0] addr;
  logic [7:0]    len;
  logic [1:0]    burst;
  logic [DW-1:0] wdata_i, rdata_o;
  logic addr_ok, data_ok, last_ok, wb_ok, resp_err, busy;

  sramlike_axi_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) axi();

  sramlike_axi_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .RD_ID(0), .WR_ID(1)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr),
    .size(size), .addr(addr), .len(len), .burst(burst),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .addr_ok(addr_ok),
    .data_ok(data_ok), .last_ok(last_ok), .wb_ok(wb_ok),
    .resp_err(resp_err), .busy(busy), .axi(axi)
  );

  logic          req2, wr2;
  logic [2:0]    size2;
  logic [AW-1:0] addr2;
  logic [7:0]    len2;
  logic [1:0]    burst2;
  logic [63:0]   wdata2, rdata2;
  logic addr_ok2, data_ok2, last_ok2, wb_ok2, resp_err2, busy2;

  sramlike_axi_bridge_if #(.DATA_W(64), .ADDR_W(AW), .ID_W(IW)) ax64();

  sramlike_axi_bridge #(
    .DATA_W(64), .ADDR_W(AW), .ID_W(IW), .RD_ID(0), .WR_ID(1)
  ) dut64 (
    .clk(clk), .resetn(resetn), .req(req2), .wr(wr2),
    .size(size2), .addr(addr2), .len(len2), .burst(burst2),
    .wdata_i(wdata2), .rdata_o(rdata2), .addr_ok(addr_ok2),
    .data_ok(data_ok2), .last_ok(last_ok2), .wb_ok(wb_ok2),
    .resp_err(resp_err2), .busy(busy2), .axi(ax64)
  );

  int checks = 0;
  int failures = 0;

  int ph = P_IDLE;
  bit m_wr, m_err;
  logic [AW-1:0] m_addr;
  int m_len, m_size, m_burst, m_beat;

  bit p_valid, p_wr;
  logic [AW-1:0] p_addr;
  int p_len, p_size, p_burst;

  int rdy_pct = 100, req_pct = 100, err_pct = 0;
  bit rd_fixed;
  logic [31:0] rd_value;
  int early_rlast = -1, force_bresp = 0;
  bit in_rst = 1'b1;

  int n_addr, n_data, n_last, n_wb, n_wlast;
  logic [31:0] last_rdata;
  logic [3:0]  last_wstrb;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [AW-1:0] a,
                                          input int ln, input int sz);
    int m;
    if (ln != 0) return 4'hF;
    m = ((1 << (1 << sz)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  task automatic drive();
    req = 1'b0; wr = 1'($urandom); size = 3'($urandom);
    addr = $urandom; len = 8'($urandom); burst = 2'($urandom);
    wdata_i = $urandom;
    axi.arready = pct(rdy_pct); axi.awready = pct(rdy_pct);
    axi.wready = pct(rdy_pct);
    axi.rvalid = 1'b0; axi.rdata = $urandom;
    axi.rresp = 2'($urandom); axi.rlast = 1'($urandom);
    axi.rid = 4'd0; axi.bid = 4'd1;
    axi.bvalid = 1'b0; axi.bresp = 2'($urandom);
    if (in_rst) begin
      wr = 1'b0; axi.arready = 1'b0; axi.awready = 1'b0;
      axi.wready = 1'b0;
      return;
    end
    case (ph)
      P_IDLE: if (p_valid && pct(req_pct)) begin
        req = 1'b1; wr = p_wr; addr = p_addr; len = p_len[7:0];
        size = p_size[2:0]; burst = p_burst[1:0];
      end
      P_DATA: if (m_wr) req = pct(req_pct);
      else if (pct(rdy_pct)) begin
        axi.rvalid = 1'b1;
        axi.rdata = rd_fixed ? rd_value : $urandom;
        axi.rresp = pct(err_pct) ? 2'($urandom_range(3, 1)) : 2'd0;
        axi.rlast = (early_rlast >= 0) ? (m_beat == early_rlast)
                                       : (m_beat == m_len);
        if (pct(err_pct / 2)) axi.rlast = !axi.rlast;
      end
      P_RESP: begin
        req = pct(50);
        if (pct(rdy_pct)) begin
          axi.bvalid = 1'b1;
          if (force_bresp != 0) axi.bresp = 2'(force_bresp);
          else axi.bresp = pct(err_pct) ? 2'($urandom_range(3, 1))
                                        : 2'd0;
        end
      end
      default: req = pct(50);
    endcase
  endtask

  task automatic compare();
    bit rda, rdd, wra, wrd, wrr, rhs, whs, bhs, fin;
    rda = (ph == P_ADDR) && !m_wr;
    wra = (ph == P_ADDR) && m_wr;
    rdd = (ph == P_DATA) && !m_wr;
    wrd = (ph == P_DATA) && m_wr;
    wrr = (ph == P_RESP);
    fin = (m_beat == m_len);
    rhs = rdd && axi.rvalid;
    whs = wrd && req && axi.wready;
    bhs = wrr && axi.bvalid;
    chk("busy", busy, ph != P_IDLE);
    chk("arvalid", axi.arvalid, rda);
    chk("awvalid", axi.awvalid, wra);
    chk("rready", axi.rready, rdd);
    chk("wvalid", axi.wvalid, wrd && req);
    chk("bready", axi.bready, wrr);
    chk("resp_err", resp_err, m_err);
    chk("addr_ok", addr_ok,
        (rda && axi.arready) || (wra && axi.awready));
    chk("data_ok", data_ok, rhs || whs);
    chk("last_ok", last_ok, (rhs || whs) && fin);
    chk("wb_ok", wb_ok, (rhs && fin) || bhs);
    if (rda) begin
      chk("araddr", axi.araddr, m_addr);
      chk("arlen", axi.arlen, m_len);
      chk("arsize", axi.arsize, m_size);
      chk("arburst", axi.arburst, m_burst);
      chk("arid", axi.arid, 0);
      chk("ar_tie", {axi.arlock, axi.arcache, axi.arprot}, 0);
    end
    if (wra) begin
      chk("awaddr", axi.awaddr, m_addr);
      chk("awlen", axi.awlen, m_len);
      chk("awsize", axi.awsize, m_size);
      chk("awburst", axi.awburst, m_burst);
      chk("awid", axi.awid, 1);
      chk("aw_tie", {axi.awlock, axi.awcache, axi.awprot}, 0);
    end
    if (rhs) chk("rdata_o", rdata_o, axi.rdata);
    if (wrd) begin
      chk("wdata", axi.wdata, wdata_i);
      chk("wlast", axi.wlast, fin);
      chk("wstrb", axi.wstrb, exp_strb(m_addr, m_len, m_size));
      chk("wid", axi.wid, 1);
    end
    if (addr_ok) n_addr++;
    if (data_ok) n_data++;
    if (last_ok) n_last++;
    if (wb_ok) n_wb++;
    if (axi.wvalid && axi.wready) begin
      last_wstrb = axi.wstrb;
      if (axi.wlast) n_wlast++;
    end
    if (axi.rvalid && axi.rready) last_rdata = rdata_o;
    case (ph)
      P_IDLE: if (req) begin
        m_wr = wr; m_addr = addr; m_len = int'(len);
        m_size = int'(size); m_burst = int'(burst);
        m_beat = 0; m_err = 1'b0; ph = P_ADDR; p_valid = 1'b0;
      end
      P_ADDR: if (m_wr ? axi.awready : axi.arready) ph = P_DATA;
      P_DATA: begin
        if (rhs) begin
          if (axi.rresp != 2'd0 || axi.rlast != fin) m_err = 1'b1;
          if (fin) ph = P_IDLE; else m_beat++;
        end
        if (whs) begin
          if (fin) ph = P_RESP; else m_beat++;
        end
      end
      default: if (bhs) begin
        if (axi.bresp != 2'd0) m_err = 1'b1;
        ph = P_IDLE;
      end
    endcase
  endtask

  always @(negedge clk) begin
    #2;
    if (!in_rst) compare();
  end

  task automatic step();
    @(negedge clk);
    drive();
  endtask

  task automatic clr_counts();
    n_addr = 0; n_data = 0; n_last = 0; n_wb = 0; n_wlast = 0;
  endtask

  task automatic do_txn(input bit w, input logic [31:0] a,
                        input int l, input int sz, input int bu);
    int k;
    p_wr = w; p_addr = a; p_len = l; p_size = sz; p_burst = bu;
    p_valid = 1'b1;
    clr_counts();
    k = 0;
    do begin
      step();
      k++;
    end while ((p_valid || ph != P_IDLE) && k < LIMIT);
    chk("txn_done", k < LIMIT, 1);
    #3;
  endtask

  initial begin
    int k;
    req2 = 1'b0; wr2 = 1'b1; size2 = 3'd1; addr2 = 32'h6;
    len2 = 8'd0; burst2 = 2'd1; wdata2 = 64'h1122334455667788;
    ax64.arready = 1'b0; ax64.rvalid = 1'b0; ax64.rdata = '0;
    ax64.rresp = '0; ax64.rlast = 1'b0; ax64.rid = '0;
    ax64.awready = 1'b1; ax64.wready = 1'b1; ax64.bvalid = 1'b1;
    ax64.bresp = '0; ax64.bid = 4'd1;
    drive();
    repeat (2) @(negedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid,
                       axi.rready, axi.bready}, 0);
    chk("rst_pulses", {addr_ok, data_ok, last_ok, wb_ok}, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_araddr", axi.araddr, 0);
    resetn = 1'b1;
    in_rst = 1'b0;

    rd_fixed = 1'b1; rd_value = 32'hDEADBEEF; rdy_pct = 40;
    do_txn(1'b0, 32'h1FC00004, 0, 2, 1);
    chk("rd1_addr_ok", n_addr, 1);
    chk("rd1_data_ok", n_data, 1);
    chk("rd1_last_ok", n_last, 1);
    chk("rd1_wb_ok", n_wb, 1);
    chk("rd1_rdata", last_rdata, 32'hDEADBEEF);
    chk("rd1_err", resp_err, 0);
    rd_fixed = 1'b0;

    rdy_pct = 50;
    do_txn(1'b0, 32'h00000100, 7, 2, 1);
    chk("rd8_data_ok", n_data, 8);
    chk("rd8_last_ok", n_last, 1);

    do_txn(1'b1, 32'h10000003, 0, 0, 1);
    chk("wb_strb", last_wstrb, 4'b1000);
    chk("wb_wlast", n_wlast, 1);
    chk("wb_wb_ok", n_wb, 1);

    rdy_pct = 40;
    do_txn(1'b1, 32'h00000040, 3, 2, 1);
    chk("w4_data_ok", n_data, 4);
    chk("w4_wlast", n_wlast, 1);
    chk("w4_last_ok", n_last, 1);
    chk("w4_strb", last_wstrb, 4'hF);

    force_bresp = 2;
    do_txn(1'b1, 32'h00000080, 1, 2, 1);
    chk("bresp_err", resp_err, 1);
    chk("bresp_wb_ok", n_wb, 1);
    force_bresp = 0;

    early_rlast = 2;
    do_txn(1'b0, 32'h00000200, 3, 2, 1);
    chk("rlast_err", resp_err, 1);
    chk("rlast_data_ok", n_data, 4);
    chk("rlast_wb_ok", n_wb, 1);
    early_rlast = -1;

    do_txn(1'b0, 32'h00000300, 0, 2, 1);
    chk("err_cleared", resp_err, 0);

    rdy_pct = 100;
    do_txn(1'b1, 32'h00001000, 255, 2, 1);
    chk("w256_data_ok", n_data, 256);
    chk("w256_wlast", n_wlast, 1);
    chk("w256_last_ok", n_last, 1);
    chk("w256_wb_ok", n_wb, 1);

    p_wr = 1'b0; p_addr = 32'h400; p_len = 7; p_size = 2;
    p_burst = 1; p_valid = 1'b1;
    clr_counts();
    k = 0;
    do begin
      step();
      k++;
    end while (!(ph == P_DATA && m_beat >= 3) && k < 100);
    chk("rst_mid_reach", k < 100, 1);
    #3;
    in_rst = 1'b1;
    resetn = 1'b0;
    #1;
    chk("arst_valids", {axi.arvalid, axi.awvalid, axi.wvalid,
                        axi.rready, axi.bready}, 0);
    chk("arst_pulses", {addr_ok, data_ok, last_ok, wb_ok}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_no_wb", n_wb, 0);
    step();
    #3;
    resetn = 1'b1;
    ph = P_IDLE; m_err = 1'b0; m_beat = 0; p_valid = 1'b0;
    in_rst = 1'b0;
    do_txn(1'b0, 32'h00000500, 2, 2, 1);
    chk("post_rst_data", n_data, 3);
    chk("post_rst_wb", n_wb, 1);

    for (int t = 0; t < 60; t++) begin
      int l;
      rdy_pct = int'($urandom_range(100, 30));
      req_pct = int'($urandom_range(100, 40));
      err_pct = (t % 3 == 0) ? 15 : 0;
      l = ($urandom_range(9) == 0) ? int'($urandom_range(63))
                                   : int'($urandom_range(7));
      do_txn(1'($urandom), $urandom, l,
             int'($urandom_range(2)), int'($urandom_range(2)));
      chk("rnd_wb", n_wb, 1);
      chk("rnd_data", n_data, l + 1);
      chk("rnd_last", n_last, 1);
    end

    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    #2;
    chk("w64_awvalid", ax64.awvalid, 1);
    chk("w64_awsize", ax64.awsize, 1);
    @(negedge clk);
    #2;
    chk("w64_wvalid", ax64.wvalid, 1);
    chk("w64_wstrb", ax64.wstrb, 8'b1100_0000);
    chk("w64_wlast", ax64.wlast, 1);
    chk("w64_wdata", ax64.wdata, 64'h1122334455667788);
    @(negedge clk);
    req2 = 1'b0;
    #2;
    chk("w64_bready", ax64.bready, 1);
    chk("w64_wb_ok", wb_ok2, 1);
    @(negedge clk);
    #2;
    chk("w64_idle", busy2, 0);
    chk("w64_err", resp_err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
Parametrised SRAM-like to AXI3 master bridge, the successor to the current combinational adaptor. It registers each request's address, length, size and burst type at acceptance and runs one read or one write burst at a time through a state machine. It counts beats internally to generate wlast and to check rlast, and returns per-beat data_ok plus a write-response/completion strobe. It sits between the cache/uncached access unit and the AXI crossbar.

Parameters:
DATA_W, 32, data bus width in bits (32 or 64); STRB_W = DATA_W/8.
ADDR_W, 32, address width.
ID_W, 4, AXI ID width.
RD_ID, 0, constant arid value.
WR_ID, 1, constant awid/wid value.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  1  request valid; in write-data phase, also marks wdata as valid
wr  in  1  1 = write, 0 = read; sampled with req in IDLE
size  in  3  bytes per beat = 2^size; must not exceed STRB_W bytes
addr  in  ADDR_W  start address
len  in  8  beats minus 1
burst  in  2  AXI burst type (0 fixed, 1 incr, 2 wrap)
wdata_i  in  DATA_W  write beat data
rdata_o  out  DATA_W  read beat data
addr_ok  out  1  pulse on the AR or AW handshake
data_ok  out  1  pulse on each accepted R or W beat
last_ok  out  1  high together with data_ok on the final beat
wb_ok  out  1  completion pulse: B handshake for writes, last R beat for reads
resp_err  out  1  sticky; set on nonzero rresp/bresp or an rlast mismatch; cleared on the next acceptance
busy  out  1  state != IDLE
ar*/r*/aw*/w*/b*  AXI3 master  standard  arid..arvalid, arready; rid, rdata, rresp, rlast, rvalid, rready; awid..awvalid, awready; wid, wdata, wstrb, wlast, wvalid, wready; bid, bresp, bvalid, bready. lock/cache/prot tied to 0.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok, last_ok, wb_ok, resp_err all 0; beat counter 0; latched fields 0. A reset during a transaction abandons it with no completion pulse.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE: when req is high, latch addr/len/size/burst/wr, clear the counter and resp_err, then go to RD_ADDR (wr=0) or WR_ADDR (wr=1). The request is taken in the cycle req is seen.
- RD_ADDR: arvalid=1, driven from latched fields (stable until the handshake). On arready go to RD_DATA with addr_ok=1 that cycle (combinational).
- RD_DATA: rready=1 (level, not toggled). Each rvalid beat: data_ok=1, rdata_o=rdata (combinational pass-through), counter +1. Final beat is counter==len. rlast on a non-final beat, or missing on the final beat, sets resp_err; the bridge still ends on counter==len. Final beat: last_ok=1, wb_ok=1, go to IDLE.
- WR_ADDR: awvalid=1. On awready go to WR_DATA with addr_ok=1.
- WR_DATA: wvalid=req; wdata=wdata_i; wlast=(counter==len). On wvalid&wready: data_ok=1, counter +1. On the last beat, last_ok=1 and go to WR_RESP.
- wstrb: if len==0, wstrb = ((1<<2^size)-1) << addr[log2(STRB_W)-1:0]. If len>0, all ones.
- WR_RESP: bready=1. On bvalid: wb_ok=1, resp_err |= (bresp!=0), go to IDLE.
- Counter is 8 bits. len=255 runs 256 beats with no wrap before completion.
- Back-to-back: a new req is accepted no earlier than the cycle after a return to IDLE.

Test Plan:
- Single word read addr=0x1FC0_0004, len=0, arready after 2 cycles, rdata=0xDEADBEEF with rlast -> one addr_ok; one data_ok with last_ok and wb_ok; rdata_o=0xDEADBEEF; resp_err=0.
- 8-beat INCR read, rvalid gapped every other cycle, rlast on beat 7 -> 8 data_ok pulses; last_ok only on beat 7; rready held at 1 throughout.
- Byte write size=0 addr=0x...3 len=0 -> wstrb=4'b1000, wlast=1; wb_ok only after bvalid; 4-beat write with wready stalls -> wlast only on beat 3.
- bresp=2'b10 on a write, or rlast early on beat 2 of a 4-beat read -> resp_err=1; completion still signalled; resp_err cleared at the next accepted req.
- Assert resetn low in RD_DATA after 3 of 8 beats -> all valids 0 asynchronously, no wb_ok; a new read after reset completes normally.
- DATA_W=64, half-word write addr=0x6 -> wstrb=8'b1100_0000; arsize/awsize equal size.
